// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: Gray-coded A/B phases, wrapping position and a step strobe.
// Define INDEX_EN to add the index pulse Z and the signed revolution counter rev_count.
module quad_encoder_gen #(
  parameter int CPR   = 1024,
  parameter int POS_W = 16,
  parameter int DIV_W = 16,
  parameter int REV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             horario,
  input  logic             antihorario,
  input  logic [DIV_W-1:0] div,
  output logic             A,
  output logic             B,
  output logic             Z,
  output logic [POS_W-1:0] position,
  output logic             dir,
  output logic             step_pulse,
  output logic [REV_W-1:0] rev_count
);

  localparam logic [1:0]       PH_00    = 2'b00;
  localparam logic [1:0]       PH_10    = 2'b10;
  localparam logic [1:0]       PH_11    = 2'b11;
  localparam logic [1:0]       PH_01    = 2'b01;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(CPR - 1);

  logic [1:0]       phase, phase_next;
  logic [DIV_W-1:0] prescaler, prescaler_next;
  logic [POS_W-1:0] pos_next;
  logic             req_valid, req_cw, prev_valid, prev_cw, dir_change, step;

  // A direction reversal between two consecutive valid cycles restarts the period.
  always_comb begin
    req_valid      = horario ^ antihorario;
    req_cw         = horario;
    dir_change     = req_valid && prev_valid && (req_cw != prev_cw);
    step           = req_valid && !dir_change && (prescaler >= div);
    prescaler_next = (!req_valid || dir_change || step) ? '0 : prescaler + DIV_W'(1);

    pos_next   = position;
    phase_next = phase;
    if (step) begin
      if (req_cw) begin
        pos_next = (position == POS_LAST) ? '0 : position + POS_W'(1);
        case (phase)
          PH_00: phase_next = PH_10;
          PH_10: phase_next = PH_11;
          PH_11: phase_next = PH_01;
          PH_01: phase_next = PH_00;
        endcase
      end else begin
        pos_next = (position == '0) ? POS_LAST : position - POS_W'(1);
        case (phase)
          PH_00: phase_next = PH_01;
          PH_01: phase_next = PH_11;
          PH_11: phase_next = PH_10;
          PH_10: phase_next = PH_00;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase      <= PH_00;
      position   <= '0;
      dir        <= 1'b0;
      step_pulse <= 1'b0;
      prescaler  <= '0;
      prev_valid <= 1'b0;
      prev_cw    <= 1'b0;
    end else begin
      phase      <= phase_next;
      position   <= pos_next;
      step_pulse <= step;
      prescaler  <= prescaler_next;
      prev_valid <= req_valid;
      prev_cw    <= req_cw;
      if (step) dir <= req_cw;
    end
  end

  assign A = phase[1];
  assign B = phase[0];

`ifdef INDEX_EN
  logic wrap_cw, wrap_ccw;

  always_comb begin
    wrap_cw  = step && req_cw && (position == POS_LAST);
    wrap_ccw = step && !req_cw && (position == '0);
  end

  // Z follows the registered position, so it rises together with position reaching 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      Z         <= 1'b1;
      rev_count <= '0;
    end else begin
      Z <= (pos_next == '0);
      if (wrap_cw)       rev_count <= rev_count + REV_W'(1);
      else if (wrap_ccw) rev_count <= rev_count - REV_W'(1);
    end
  end
`else
  assign Z         = 1'b0;
  assign rev_count = '0;
`endif

endmodule
